text_ram_writer: RTL

//  Write side of the text-mode display RAM. Accepts a stream of {attr,ascii} characters

---
 rtl/text_ram_writer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/text_ram_writer.sv
// rtl/text_ram_writer.sv - cursor-tracking character writer for text-mode display RAM port B
//
// Ports:
//   clk, rst_n          clock (also RAM clkb) and asynchronous active-low reset
//   text_base[15:0]     word address of cell (0,0); low AW bits used
//   clear_attr[7:0]     attribute byte written into cleared cells
//   char_valid/ready    character handshake; char_data = ASCII, char_attr = attribute
//   web/addrb/dinb      RAM port-B write strobe, address, {attr, ascii} data
//   cur_col/cur_row     cursor position
//   busy                high while a line or full-screen clear runs
module text_ram_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         AW         = 14,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   text_base,
  input  logic [7:0]    clear_attr,
  input  logic          char_valid,
  output logic          char_ready,
  input  logic [7:0]    char_data,
  input  logic [7:0]    char_attr,
  output logic          web,
  output logic [AW-1:0] addrb,
  output logic [15:0]   dinb,
  output logic [6:0]    cur_col,
  output logic [5:0]    cur_row,
  output logic          busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WRITE    = 2'd1;
  localparam logic [1:0] S_CLR_LINE = 2'd2;
  localparam logic [1:0] S_CLR_ALL  = 2'd3;

  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_FF = 8'h0C;

  logic [1:0]    state;
  logic [AW-1:0] row_base;      // cur_row * COLS, stepped incrementally
  logic [6:0]    clr_col;
  logic [5:0]    clr_row;
  logic [AW-1:0] clr_rb;        // row base of the row being cleared
  logic          clr_done;      // last clear write already issued
  logic          wrap_pend;     // printable hit the last column; clear new row after write

  logic [AW-1:0] base;
  logic          last_col;
  logic          last_row;
  logic [5:0]    next_row;
  logic [AW-1:0] next_row_base;
  logic          accept;

  assign base   = text_base[AW-1:0];
  assign accept = char_valid & char_ready;

  generate
    if (AW < 16) begin : g_unused_base
      logic unused_base_bits;
      assign unused_base_bits = ^text_base[15:AW];
    end
  endgenerate

  always_comb begin
    last_col      = (cur_col == 7'(COLS - 1));
    last_row      = (cur_row == 6'(ROWS - 1));
    next_row      = last_row ? 6'd0 : cur_row + 6'd1;
    next_row_base = last_row ? '0 : row_base + AW'(COLS);
  end

  function automatic logic [AW-1:0] cell_addr(input logic [AW-1:0] b,
                                              input logic [AW-1:0] rb,
                                              input logic [6:0]    c);
    return b + rb + AW'(c);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLR_ALL;
      cur_col    <= '0;
      cur_row    <= '0;
      row_base   <= '0;
      web        <= 1'b0;
      addrb      <= '0;
      dinb       <= '0;
      char_ready <= 1'b0;
      busy       <= 1'b1;
      clr_col    <= '0;
      clr_row    <= '0;
      clr_rb     <= '0;
      clr_done   <= 1'b0;
      wrap_pend  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          web <= 1'b0;
          if (accept) begin
            char_ready <= 1'b0;
            wrap_pend  <= 1'b0;
            case (char_data)
              C_CR: begin
                // Pass through S_WRITE without a strobe so ready drops for one cycle.
                cur_col <= '0;
                state   <= S_WRITE;
              end
              C_LF: begin
                cur_col  <= '0;
                cur_row  <= next_row;
                row_base <= next_row_base;
                clr_col  <= '0;
                clr_rb   <= next_row_base;
                clr_done <= 1'b0;
                busy     <= 1'b1;
                state    <= S_CLR_LINE;
              end
              C_BS: begin
                state <= S_WRITE;
                if (cur_col != 7'd0) begin
                  cur_col <= cur_col - 7'd1;
                  web     <= 1'b1;
                  addrb   <= cell_addr(base, row_base, cur_col - 7'd1);
                  dinb    <= {clear_attr, BLANK_CHAR};
                end
              end
              C_FF: begin
                clr_col  <= '0;
                clr_row  <= '0;
                clr_rb   <= '0;
                clr_done <= 1'b0;
                busy     <= 1'b1;
                state    <= S_CLR_ALL;
              end
              default: begin
                // Strobe is launched at the handshake edge so web shows one cycle later.
                web   <= 1'b1;
                addrb <= cell_addr(base, row_base, cur_col);
                dinb  <= {char_attr, char_data};
                state <= S_WRITE;
                if (last_col) begin
                  cur_col   <= '0;
                  cur_row   <= next_row;
                  row_base  <= next_row_base;
                  wrap_pend <= 1'b1;
                end else begin
                  cur_col <= cur_col + 7'd1;
                end
              end
            endcase
          end
        end

        S_WRITE: begin
          web <= 1'b0;
          if (wrap_pend) begin
            // row_base already points at the new row.
            wrap_pend <= 1'b0;
            clr_col   <= '0;
            clr_rb    <= row_base;
            clr_done  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CLR_LINE;
          end else begin
            char_ready <= 1'b1;
            state      <= S_IDLE;
          end
        end

        S_CLR_LINE, S_CLR_ALL: begin
          if (clr_done) begin
            web        <= 1'b0;
            busy       <= 1'b0;
            char_ready <= 1'b1;
            state      <= S_IDLE;
            if (state == S_CLR_ALL) begin
              cur_col  <= '0;
              cur_row  <= '0;
              row_base <= '0;
            end
          end else begin
            web   <= 1'b1;
            addrb <= cell_addr(base, clr_rb, clr_col);
            dinb  <= {clear_attr, BLANK_CHAR};
            if (clr_col == 7'(COLS - 1)) begin
              clr_col  <= '0;
              clr_row  <= clr_row + 6'd1;
              clr_rb   <= clr_rb + AW'(COLS);
              clr_done <= (state == S_CLR_LINE) || (clr_row == 6'(ROWS - 1));
            end else begin
              clr_col <= clr_col + 7'd1;
            end
          end
        end

        default: state <= S_CLR_ALL;
      endcase
    end
  end

endmodule
